// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and helpers for the nibble-serial adder (package nsa_pkg).
package nsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_e;

  localparam int NIBBLE_W = 4;

  // Width of the nibble index counter; never narrower than one bit.
  function automatic int idx_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice, shared across all nibble passes.
module cla4_slice (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Every carry is expanded in full generate/propagate form back to the slice carry-in.
  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum  = w_p ^ w_c[3:0];
  assign o_cout = w_c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that time-shares one cla4_slice, least significant nibble first.
// Optional macro NSA_SUB_EN adds a 'sub' port for a-b (borrow reported as cout=0).
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NSA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = idx_width(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  nsa_state_e       r_state;
  nsa_state_e       w_next_state;
  logic             w_accept;
  logic             w_step;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_b_cap;
  logic             w_cin_cap;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;

`ifdef NSA_SUB_EN
  // Subtraction is a + ~b + 1, so the operand is inverted once at capture.
  assign w_b_cap   = sub ? ~b : b;
  assign w_cin_cap = sub ? 1'b1 : cin;
`else
  assign w_b_cap   = b;
  assign w_cin_cap = cin;
`endif

  assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
  assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];

  cla4_slice u_slice (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && r_in_ready) begin
          w_accept     = 1'b1;
          w_next_state = RUN;
        end else begin
          w_next_state = IDLE;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_next_state = DONE;
        end else begin
          w_next_state = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DONE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Handshake flags follow the next state so they are valid for the whole cycle they cover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_next_state == IDLE);
      r_out_valid <= (w_next_state == DONE);
      if (w_accept) begin
        r_a     <= a;
        r_b     <= w_b_cap;
        r_carry <= w_cin_cap;
        r_idx   <= '0;
      end else if (w_step) begin
        r_sum[{r_idx, 2'b00} +: 4] <= w_slice_sum;
        r_carry                    <= w_slice_cout;
        r_idx                      <= r_idx + IDX_W'(1);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_carry;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16); exercises 'sub' when NSA_SUB_EN is defined.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef NSA_SUB_EN
  logic             sub = 1'b0;
`endif

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef NSA_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
  } res_t;

  res_t exp_q[$];
  vec_t vt[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input vec_t v);
    a   = v.a;
    b   = v.b;
    cin = v.cin;
`ifdef NSA_SUB_EN
    sub = v.sub;
`endif
    in_valid = 1'b1;
  endtask

  // One complete operation: accept, latency check, result check, optional backpressure, release.
  task automatic run_op(input vec_t v, input int hold);
    int   guard;
    int   t_acc;
    res_t r;
    res_t e;
    drive(v);
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick;
      guard++;
    end
    check("accept_ready", in_ready, 1);
    e.s = v.exp_sum;
    e.c = v.exp_cout;
    exp_q.push_back(e);
    t_acc = cyc;
    tick;
    in_valid = 1'b0;
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = ~cin;
`ifdef NSA_SUB_EN
    sub = ~sub;
`endif
    guard = 0;
    while (!out_valid && guard < 20) begin
      check("run_in_ready", in_ready, 0);
      tick;
      guard++;
    end
    check("latency", cyc - t_acc, NIB + 1);
    r = exp_q.pop_front();
    check("sum", sum, r.s);
    check("cout", cout, r.c);
    check("done_in_ready", in_ready, 0);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      tick;
      check("bp_out_valid", out_valid, 1);
      check("bp_sum", sum, r.s);
      check("bp_cout", cout, r.c);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  function automatic vec_t mk(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                              input logic vc, input logic vs,
                              input logic [WIDTH-1:0] es, input logic ec);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vc; v.sub = vs; v.exp_sum = es; v.exp_cout = ec;
    return v;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   acc_cyc[$];
    int   guard;
    res_t r;
    res_t e;
    logic [WIDTH:0] full;
    vec_t v;

    vt.push_back(mk(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0));
    vt.push_back(mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1));
    vt.push_back(mk(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0));
    vt.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0));
    vt.push_back(mk(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0));
    vt.push_back(mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1));
    vt.push_back(mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1));
    vt.push_back(mk(16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0));
`ifdef NSA_SUB_EN
    vt.push_back(mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0));
    vt.push_back(mk(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1));
    vt.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1));
`endif
    for (int i = 0; i < 4; i++) begin
      v.a = 16'($urandom);
      v.b = 16'($urandom);
      v.cin = 1'($urandom);
      v.sub = 1'b0;
      full = {1'b0, v.a} + {1'b0, v.b} + {16'h0000, v.cin};
      v.exp_sum = full[WIDTH-1:0];
      v.exp_cout = full[WIDTH];
      vt.push_back(v);
    end

    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    check("rel_in_ready_low", in_ready, 0);
    tick;
    check("rel_in_ready_high", in_ready, 1);
    check("rel_out_valid", out_valid, 0);

    for (int i = 0; i < vt.size(); i++) begin
      run_op(vt[i], 0);
    end

    run_op(mk(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0), 10);

    // Reset in the second RUN cycle; nibble 0 (0x3) is already written.
    drive(mk(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0));
    tick;
    in_valid = 1'b0;
    tick;
    #2 rst_n = 1'b0;
    #1;
    check("abort_run_out_valid", out_valid, 0);
    check("abort_run_sum", sum, 0);
    check("abort_run_in_ready", in_ready, 0);
    #3 rst_n = 1'b1;
    check("abort_run_rel_in_ready", in_ready, 0);
    tick;
    check("abort_run_idle", in_ready, 1);
    run_op(mk(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0), 0);

    // Reset while a result is held in DONE.
    drive(mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1));
    tick;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin
      tick;
      guard++;
    end
    check("pre_abort_done", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_done_out_valid", out_valid, 0);
    check("abort_done_cout", cout, 0);
    #3 rst_n = 1'b1;
    tick;
    check("abort_done_idle", in_ready, 1);

    // Back-to-back operations with out_ready held high.
    a = 16'h0101; b = 16'h0202; cin = 1'b0;
`ifdef NSA_SUB_EN
    sub = 1'b0;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      in_valid = (i < 40);
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        e.s = 16'h0303;
        e.c = 1'b0;
        exp_q.push_back(e);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("tp_unexpected_output", 1, 0);
        end else begin
          r = exp_q.pop_front();
          check("tp_sum", sum, r.s);
          check("tp_cout", cout, r.c);
        end
      end
      tick;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("tp_accepts", acc_cyc.size(), 7);
    for (int i = 1; i < acc_cyc.size(); i++) begin
      check("tp_spacing", acc_cyc[i] - acc_cyc[i-1], NIB + 2);
    end
    check("tp_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
